// File: rtl/canvas_pkg.sv
// Shared constants and types for the small-canvas port arbiter.
// Holds canvas geometry, the arbiter state enum and the drop counter width.
package canvas_pkg;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;
   localparam int DROP_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      REC,
      CLEAR
   } state_e;
endpackage

// File: rtl/clear_sweeper.sv
// Address generator for the canvas clear sweep.
// start: reload cnt to 0; run: advance; addr: sweep address; last: cnt==DEPTH-1.
module clear_sweeper
   import canvas_pkg::*;
#(
   parameter int ADDR_W = canvas_pkg::ADDR_W,
   parameter int DEPTH  = canvas_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              run,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   // One spare bit so DEPTH == 2**ADDR_W ends without wrapping.
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

   logic [ADDR_W:0] cnt_q;
   logic [ADDR_W:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign addr = cnt_q[ADDR_W-1:0];
   assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/canvas_port_arbiter.sv
// Shares the single canvas RAM port between mouse writes, recognizer reads
// and a clear sweep (priority CLEAR > REC > mouse); counts dropped writes.
// Ports: mouse_*, rec_*, clear_*, drop status, ram_* towards the canvas RAM.
module canvas_port_arbiter
   import canvas_pkg::*;
#(
   parameter int ADDR_W = canvas_pkg::ADDR_W,
   parameter int DEPTH  = canvas_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mouse_we,
   input  logic [ADDR_W-1:0] mouse_addr,
   input  logic              mouse_data,
   input  logic              rec_req,
   input  logic [ADDR_W-1:0] rec_addr,
   output logic              rec_gnt,
   output logic              rec_rdata,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              mouse_dropped,
   output logic [7:0]        drop_cnt,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_d,
   output logic              ram_we,
   input  logic              ram_spo
);

   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   state_e              state_q, state_d;
   logic                pend_q, pend_d;
   logic                done_q, done_d;
   logic                dropped_q, dropped_d;
   logic [DROP_W-1:0]   drop_q, drop_d;
   logic                sw_start;
   logic                sw_run;
   logic                sw_last;
   logic [ADDR_W-1:0]   sw_addr;
   logic                drop_hit;
   logic                we_mux;

   clear_sweeper #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_sweeper (
      .clk   (clk),
      .rst   (rst),
      .start (sw_start),
      .run   (sw_run),
      .addr  (sw_addr),
      .last  (sw_last)
   );

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      done_d   = 1'b0;
      sw_start = 1'b0;
      sw_run   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (clear_start || pend_q) begin
               state_d  = CLEAR;
               sw_start = 1'b1;
            end else if (rec_req) begin
               state_d = REC;
            end
         end
         REC: begin
            // A clear request is parked until the burst ends.
            if (clear_start) begin
               pend_d = 1'b1;
            end
            if (!rec_req) begin
               if (pend_q || clear_start) begin
                  state_d  = CLEAR;
                  sw_start = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         CLEAR: begin
            sw_run = 1'b1;
            if (sw_last) begin
               state_d = IDLE;
               pend_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign drop_hit  = mouse_we && (state_q != IDLE);
   assign dropped_d = drop_hit;

   always_comb begin
      drop_d = drop_q;
      if (drop_hit && (drop_q != DROP_MAX)) begin
         drop_d = drop_q + 1'b1;
      end
   end

   always_comb begin
      ram_a  = mouse_addr;
      ram_d  = mouse_data;
      we_mux = mouse_we;
      unique case (state_q)
         REC: begin
            ram_a  = rec_addr;
            ram_d  = 1'b0;
            we_mux = 1'b0;
         end
         CLEAR: begin
            ram_a  = sw_addr;
            ram_d  = 1'b0;
            we_mux = 1'b1;
         end
         default: begin
            ram_a  = mouse_addr;
            ram_d  = mouse_data;
            we_mux = mouse_we;
         end
      endcase
   end

   assign ram_we = rst ? 1'b0 : we_mux;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pend_q    <= 1'b0;
         done_q    <= 1'b0;
         dropped_q <= 1'b0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         done_q    <= done_d;
         dropped_q <= dropped_d;
         drop_q    <= drop_d;
      end
   end

   assign rec_gnt       = (state_q == REC);
   assign clear_busy    = (state_q == CLEAR);
   assign clear_done    = done_q;
   assign mouse_dropped = dropped_q;
   assign drop_cnt      = drop_q;
   assign rec_rdata     = rec_gnt & ram_spo;

endmodule

// File: tb/tb_canvas_port_arbiter.sv
// Directed bench for canvas_port_arbiter with a behavioural canvas RAM.
// Checks pass-through, read bursts, clear timing, drops and reset abort.
module tb_canvas_port_arbiter;
   localparam int AW = 10;
   localparam int N  = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          mouse_we;
   logic [AW-1:0] mouse_addr;
   logic          mouse_data;
   logic          rec_req;
   logic [AW-1:0] rec_addr;
   logic          rec_gnt;
   logic          rec_rdata;
   logic          clear_start;
   logic          clear_busy;
   logic          clear_done;
   logic          mouse_dropped;
   logic [7:0]    drop_cnt;
   logic [AW-1:0] ram_a;
   logic          ram_d;
   logic          ram_we;
   logic          ram_spo;

   logic mem [0:N-1];

   int total = 0;
   int bad   = 0;
   int pulses;

   always #5 clk = ~clk;

   canvas_port_arbiter #(
      .ADDR_W (AW),
      .DEPTH  (N)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mouse_we      (mouse_we),
      .mouse_addr    (mouse_addr),
      .mouse_data    (mouse_data),
      .rec_req       (rec_req),
      .rec_addr      (rec_addr),
      .rec_gnt       (rec_gnt),
      .rec_rdata     (rec_rdata),
      .clear_start   (clear_start),
      .clear_busy    (clear_busy),
      .clear_done    (clear_done),
      .mouse_dropped (mouse_dropped),
      .drop_cnt      (drop_cnt),
      .ram_a         (ram_a),
      .ram_d         (ram_d),
      .ram_we        (ram_we),
      .ram_spo       (ram_spo)
   );

   always @(posedge clk) begin
      if (ram_we) mem[ram_a] <= ram_d;
   end
   assign ram_spo = mem[ram_a];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic pat(input int a);
      logic [9:0] v;
      v = a[9:0];
      return v[0] ^ v[2] ^ v[5] ^ v[9];
   endfunction

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < N; i++) mem[i] = 1'b0;
      rst         = 1'b1;
      mouse_we    = 1'b1;
      mouse_addr  = 10'h3ff;
      mouse_data  = 1'b1;
      rec_req     = 1'b0;
      rec_addr    = '0;
      clear_start = 1'b0;

      // reset state; ram_we forced low despite mouse_we
      nxt;
      nxt;
      smp;
      chk("rst_we", ram_we, 0);
      chk("rst_gnt", rec_gnt, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_done", clear_done, 0);
      chk("rst_drop", mouse_dropped, 0);
      chk("rst_cnt", drop_cnt, 0);

      // mouse pass-through
      nxt;
      rst        = 1'b0;
      mouse_addr = 10'h155;
      mouse_data = 1'b1;
      smp;
      chk("m_we", ram_we, 1);
      chk("m_a", ram_a, 32'h155);
      chk("m_d", ram_d, 1);
      chk("m_cnt", drop_cnt, 0);

      // preload pattern through the mouse path
      for (int a = 0; a < N; a++) begin
         nxt;
         mouse_addr = AW'(a);
         mouse_data = pat(a);
      end
      nxt;
      mouse_we = 1'b0;
      rec_req  = 1'b1;
      smp;
      chk("gnt_pre", rec_gnt, 0);

      // burst with a clear request parked mid-way
      for (int a = 0; a < N; a++) begin
         nxt;
         rec_addr    = AW'(a);
         clear_start = (a == 100);
         if (a == N - 1) begin
            mouse_we   = 1'b1;
            mouse_addr = '0;
            mouse_data = ~pat(0);
         end
         smp;
         chk("rd_pat", rec_rdata, pat(a));
         if (a == 0) chk("gnt_rise", rec_gnt, 1);
         if (a == 500) chk("busy_rec", clear_busy, 0);
         if (a == N - 1) chk("rec_we", ram_we, 0);
      end
      nxt;
      rec_req  = 1'b0;
      mouse_we = 1'b0;
      smp;
      chk("gnt_hold", rec_gnt, 1);
      chk("rec_drop", mouse_dropped, 1);
      chk("rec_cnt", drop_cnt, 1);

      // queued clear, 300 dropped writes, rec_req waits
      pulses = 0;
      for (int k = 0; k < N; k++) begin
         nxt;
         mouse_we   = (k < 300);
         mouse_addr = AW'(k + 5);
         mouse_data = 1'b1;
         if (k == 1000) rec_req = 1'b1;
         smp;
         chk("qc_a", ram_a, k);
         chk("qc_ctl", {rec_gnt, clear_busy, ram_we, ram_d}, 4'b0110);
         if (mouse_dropped) pulses++;
      end
      nxt;
      mouse_we = 1'b0;
      smp;
      chk("qc_done", {clear_done, clear_busy, rec_gnt}, 3'b100);
      if (mouse_dropped) pulses++;
      nxt;
      smp;
      chk("qc_gnt", rec_gnt, 1);
      chk("qc_done0", clear_done, 0);
      chk("drop_pulses", pulses, 300);
      chk("drop_sat", drop_cnt, 255);

      // read back: canvas all zero
      for (int a = 0; a < N; a++) begin
         rec_addr = AW'(a);
         smp;
         chk("rd_zero", {rec_gnt, rec_rdata}, 2'b10);
         nxt;
      end
      rec_req = 1'b0;
      nxt;
      smp;
      chk("gnt_fall", rec_gnt, 0);

      // clear and rec_req in the same IDLE cycle
      nxt;
      clear_start = 1'b1;
      rec_req     = 1'b1;
      smp;
      chk("cr_busy0", clear_busy, 0);
      nxt;
      clear_start = 1'b0;
      for (int k = 0; k < N; k++) begin
         smp;
         chk("cr_a", ram_a, k);
         chk("cr_ctl", {rec_gnt, clear_busy, ram_we, ram_d}, 4'b0110);
         nxt;
      end
      smp;
      chk("cr_done", {clear_done, clear_busy, rec_gnt}, 3'b100);
      nxt;
      smp;
      chk("cr_gnt", {clear_done, rec_gnt}, 2'b01);
      rec_req = 1'b0;
      nxt;
      nxt;

      // reset at the 500th cycle of a clear
      clear_start = 1'b1;
      nxt;
      clear_start = 1'b0;
      for (int k = 0; k < 499; k++) nxt;
      smp;
      chk("ab_busy", clear_busy, 1);
      chk("ab_a", ram_a, 499);
      nxt;
      rst = 1'b1;
      smp;
      chk("ab_we", ram_we, 0);
      nxt;
      rst = 1'b0;
      smp;
      chk("ab_outs", {rec_gnt, clear_busy, clear_done, mouse_dropped, ram_we}, 0);
      chk("ab_cnt", drop_cnt, 0);
      for (int k = 0; k < 3; k++) begin
         nxt;
         smp;
         chk("ab_nodone", {clear_done, clear_busy}, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/canvas_port_arbiter.md
# canvas_port_arbiter

Owns the single read/write port of the 32×32 one-bit small canvas RAM. It shares that port between three users: the mouse stroke writer, the recognizer's read-out burst, and an internal clear engine that wipes the canvas after a character is committed. It replaces the ad-hoc read-enable mux in front of the canvas and adds a sequenced, guaranteed-complete clear.

## Interface
Parameters:
- ADDR_W, 10, canvas address width
- DEPTH, 1024, number of canvas cells swept by a clear

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- mouse_we  in  1  mouse write strobe, one cell per cycle
- mouse_addr  in  ADDR_W  mouse write address
- mouse_data  in  1  mouse write data
- rec_req  in  1  recognizer read request, level; held for the whole burst
- rec_addr  in  ADDR_W  recognizer read address
- rec_gnt  out  1  recognizer owns the port
- rec_rdata  out  1  canvas read data; valid only while rec_gnt=1
- clear_start  in  1  one-cycle pulse requesting a full canvas clear
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse after the last clear write
- mouse_dropped  out  1  one-cycle pulse when a mouse write is discarded
- drop_cnt  out  8  saturating count of discarded mouse writes
- ram_a  out  ADDR_W  canvas port address
- ram_d  out  1  canvas port write data
- ram_we  out  1  canvas port write enable
- ram_spo  in  1  canvas port asynchronous read data

## Operation
- States: IDLE, REC, CLEAR. Priority is CLEAR > REC > mouse.
- IDLE behaviour:
  - Mouse passes through combinationally: ram_a=mouse_addr, ram_d=mouse_data, ram_we=mouse_we.
  - If clear_start=1 (or clear_pend=1) → CLEAR, with counter cleared to 0.
  - Else if rec_req=1 → REC.
- REC behaviour:
  - ram_a=rec_addr, ram_we=0, rec_gnt=1.
  - rec_req=0 → IDLE, or → CLEAR if clear_pend=1.
  - clear_start in REC sets clear_pend; the recognizer burst is never interrupted.
- CLEAR behaviour:
  - ram_a=cnt, ram_d=0, ram_we=1, clear_busy=1, cnt increments each cycle.
  - At cnt==DEPTH-1 → IDLE, clear_pend cleared, clear_done pulses next cycle.
  - clear_start in CLEAR is ignored; no re-queue.
  - rec_req in CLEAR waits and is served after the clear completes.
- Mouse writes arriving in REC or CLEAR are discarded. mouse_dropped pulses the next cycle, and drop_cnt increments, saturating at 255.
- rec_rdata = ram_spo when rec_gnt=1, else 0.
- While rst=1, ram_we is forced to 0.
- Reset values: state IDLE, cnt 0, clear_pend 0, rec_gnt 0, clear_busy 0, clear_done 0, mouse_dropped 0, drop_cnt 0.
- Reset mid-CLEAR aborts the sweep. The canvas is left partially cleared and no clear_done is issued.

## Timing
- rec_gnt is registered:
  - rec_req rising at cycle N in IDLE → rec_gnt=1 from N+1.
  - rec_req low at cycle M → rec_gnt=0 from M+1.
  - Requester must ignore rec_rdata until it sees rec_gnt.
- rec_rdata has zero latency relative to rec_addr (asynchronous RAM).
- Clear sampled at cycle N in IDLE:
  - Writes to addresses 0..DEPTH-1 occur at cycles N+1..N+DEPTH; clear_busy is high for exactly those cycles.
  - clear_done=1 at N+DEPTH+1, with state IDLE.
- clear_start and rec_req in the same IDLE cycle → CLEAR wins; rec_gnt is first asserted at N+DEPTH+2 at the earliest.
- Counter is ADDR_W+1 bits wide so that DEPTH=2^ADDR_W terminates cleanly without wrap.

## Structure
- Package canvas_pkg holds ADDR_W, DEPTH, the state enum (IDLE/REC/CLEAR) and the drop-counter width.
- Sub-module clear_sweeper owns cnt and the last-address detect.
  - Inputs: start, run.
  - Outputs: addr, last.
- Arbitration FSM, output mux and drop counter live in canvas_port_arbiter.

## Test plan
- Mouse only: mouse_we=1, addr=0x155, data=1 in IDLE → ram_we=1, ram_a=0x155, ram_d=1 in the same cycle; drop_cnt=0.
- Recognizer burst: rec_req high for 1024 cycles sweeping rec_addr over a preloaded pattern.
  - Required: rec_gnt rises one cycle after rec_req and falls one cycle after rec_req drops.
  - Required: rec_rdata matches the pattern at every address.
- Clear: clear_start at cycle 10 → ram_we=1 at cycles 11..1034, addr 0..1023, data 0; clear_done at 1035; a read-back of the RAM is all zero.
- Clear during read: clear_start mid-REC → the burst completes untouched; CLEAR begins the cycle after rec_req falls; clear_done follows 1024 cycles later.
- Drops: 300 mouse writes during CLEAR → no RAM writes from mouse, 300 mouse_dropped pulses, drop_cnt=255.
- Reset at cycle 500 of a clear → next cycle all outputs at reset values, ram_we=0, no clear_done.
